// File: rtl/mips_muldiv_pkg.sv
// Shared MIPS definitions for the multiply/divide unit.
// mdop_t    : operation selector driven by the decoder alongside start.
// FUNC_*    : SPECIAL-opcode function fields for the HI/LO instructions.
package mips_muldiv_pkg;

  typedef enum logic [2:0] {
    MD_MULT,
    MD_MULTU,
    MD_DIV,
    MD_DIVU,
    MD_MTHI,
    MD_MTLO
  } mdop_t;

  localparam logic [5:0] FUNC_MFHI  = 6'b010000;
  localparam logic [5:0] FUNC_MTHI  = 6'b010001;
  localparam logic [5:0] FUNC_MFLO  = 6'b010010;
  localparam logic [5:0] FUNC_MTLO  = 6'b010011;
  localparam logic [5:0] FUNC_MULT  = 6'b011000;
  localparam logic [5:0] FUNC_MULTU = 6'b011001;
  localparam logic [5:0] FUNC_DIV   = 6'b011010;
  localparam logic [5:0] FUNC_DIVU  = 6'b011011;

endpackage

// File: rtl/mips_muldiv_if.sv
// Execute-stage <-> mul/div unit bundle.
// master (pipeline): drives start/op/a/b/flush, observes busy/done/hi/lo.
// slave  (unit)    : the reverse.
interface mips_muldiv_if #(
  parameter int WIDTH = 32
);
  import mips_muldiv_pkg::*;

  logic             start;
  mdop_t            op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, flush, input busy, done, hi, lo);
  modport slave  (input start, op, a, b, flush, output busy, done, hi, lo);

endinterface

// File: rtl/mips_muldiv.sv
// Iterative MIPS multiply/divide unit with private HI/LO registers.
// clk/rst_n : clock, asynchronous active-low reset.
// bus       : start/op/a/b/flush requests in; busy/done/hi/lo out.
// One radix-2 step per cycle in CALC (WIDTH steps), then FIX applies
// signs and writes HI/LO. Multiply and divide share one 2*WIDTH
// accumulator: low half holds the multiplier / dividend bits being
// consumed, high half the partial product / partial remainder.
module mips_muldiv
  import mips_muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic         clk,
  input  logic         rst_n,
  mips_muldiv_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opb_q, opb_d;    // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   araw_q, araw_d;  // original rs, for divide-by-zero HI
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;  // product / quotient negated
  logic               neg_rem_q, neg_rem_d;  // remainder follows dividend
  logic               dz_q, dz_d;
  logic               done_q, done_d;

  // request decode and operand magnitudes
  logic             sgn_op, div_op, arith_op;
  logic [WIDTH-1:0] mag_a, mag_b;

  always_comb begin
    sgn_op   = (bus.op == MD_MULT) || (bus.op == MD_DIV);
    div_op   = (bus.op == MD_DIV)  || (bus.op == MD_DIVU);
    arith_op = (bus.op == MD_MULT) || (bus.op == MD_MULTU) || div_op;
    mag_a    = (sgn_op && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    mag_b    = (sgn_op && bus.b[WIDTH-1]) ? -bus.b : bus.b;
  end

  // single-step datapaths
  logic [WIDTH:0]     mul_sum, div_sh;
  logic [WIDTH-1:0]   div_rem;
  logic               div_ge;
  logic [2*WIDTH-1:0] mul_next, div_next, prod;
  logic [WIDTH-1:0]   quo, rem;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    // shifted partial remainder is WIDTH+1 bits; after a successful
    // subtract the result is below the divisor, so WIDTH bits suffice
    div_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    div_ge   = div_sh >= {1'b0, opb_q};
    div_rem  = div_sh[WIDTH-1:0] - opb_q;
    div_next = div_ge ? {div_rem, acc_q[WIDTH-2:0], 1'b1}
                      : {acc_q[2*WIDTH-2:0], 1'b0};
    prod     = neg_res_q ? -acc_q : acc_q;
    quo      = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem      = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    araw_d    = araw_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.flush) begin
          if (bus.op == MD_MTHI) begin
            hi_d = bus.a;
          end else if (bus.op == MD_MTLO) begin
            lo_d = bus.a;
          end else if (arith_op) begin
            state_d   = S_CALC;
            cnt_d     = '0;
            is_div_d  = div_op;
            acc_d     = {{WIDTH{1'b0}}, (div_op ? mag_a : mag_b)};
            opb_d     = div_op ? mag_b : mag_a;
            araw_d    = bus.a;
            neg_res_d = sgn_op && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            neg_rem_d = sgn_op && bus.a[WIDTH-1];
            dz_d      = div_op && (bus.b == '0);
          end
        end
      end
      S_CALC: begin
        if (bus.flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d = is_div_q ? div_next : mul_next;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH-1)) state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!bus.flush) begin
          done_d = 1'b1;
          if (!is_div_q) begin
            hi_d = prod[2*WIDTH-1:WIDTH];
            lo_d = prod[WIDTH-1:0];
          end else if (dz_q) begin
            hi_d = araw_q;
            lo_d = '1;
          end else begin
            hi_d = rem;
            lo_d = quo;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opb_q     <= '0;
      araw_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      araw_q    <= araw_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy = (state_q != S_IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mips_muldiv.sv
// Directed bench for mips_muldiv at WIDTH=32; expected values hand-computed.
module tb_mips_muldiv;
  import mips_muldiv_pkg::*;

  localparam int W = 32;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  mips_muldiv_if #(.WIDTH(W)) bus();

  mips_muldiv #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // request accepted at the next rising edge; returns 1 time unit after it
  task automatic issue(input mdop_t o, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = o;
    bus.a     = x;
    bus.b     = y;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      bad++; $display("FAIL reset_flags: got busy/done=%b want 00", {bus.busy, bus.done});
    end
    total++;
    if ({bus.hi, bus.lo} !== 64'h0) begin
      bad++; $display("FAIL reset_hilo: got %h want 0", {bus.hi, bus.lo});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_mul();
    mdop_t       vop[4];
    logic [W-1:0] va[4], vb[4], vhi[4], vlo[4];
    vop[0] = MD_MULT;  va[0] = 32'hFFFFFFFE; vb[0] = 32'd3;        vhi[0] = 32'hFFFFFFFF; vlo[0] = 32'hFFFFFFFA;
    vop[1] = MD_MULTU; va[1] = 32'hFFFFFFFF; vb[1] = 32'hFFFFFFFF; vhi[1] = 32'hFFFFFFFE; vlo[1] = 32'h00000001;
    vop[2] = MD_MULT;  va[2] = 32'd7;        vb[2] = 32'hFFFFFFFD; vhi[2] = 32'hFFFFFFFF; vlo[2] = 32'hFFFFFFEB;
    vop[3] = MD_MULT;  va[3] = 32'h80000000; vb[3] = 32'h80000000; vhi[3] = 32'h40000000; vlo[3] = 32'h00000000;
    for (int i = 0; i < 4; i++) begin
      issue(vop[i], va[i], vb[i]);
      total++;
      if (bus.busy !== 1'b1) begin
        bad++; $display("FAIL mul%0d_busy_start: got %b want 1", i, bus.busy);
      end
      step(W);
      total++;
      if ({bus.done, bus.busy} !== 2'b01) begin
        bad++; $display("FAIL mul%0d_early: got done/busy=%b want 01", i, {bus.done, bus.busy});
      end
      step(1);
      total++;
      if ({bus.done, bus.busy} !== 2'b10) begin
        bad++; $display("FAIL mul%0d_done: got done/busy=%b want 10", i, {bus.done, bus.busy});
      end
      total++;
      if ({bus.hi, bus.lo} !== {vhi[i], vlo[i]}) begin
        bad++; $display("FAIL mul%0d_result: got %h want %h", i, {bus.hi, bus.lo}, {vhi[i], vlo[i]});
      end
      step(1);
      total++;
      if (bus.done !== 1'b0) begin
        bad++; $display("FAIL mul%0d_done_pulse: got %b want 0", i, bus.done);
      end
    end
  endtask

  task automatic test_div();
    mdop_t       vop[7];
    logic [W-1:0] va[7], vb[7], vhi[7], vlo[7];
    vop[0] = MD_DIV;  va[0] = 32'hFFFFFFF9; vb[0] = 32'd2;        vlo[0] = 32'hFFFFFFFD; vhi[0] = 32'hFFFFFFFF;
    vop[1] = MD_DIVU; va[1] = 32'd7;        vb[1] = 32'd2;        vlo[1] = 32'd3;        vhi[1] = 32'd1;
    vop[2] = MD_DIV;  va[2] = 32'd7;        vb[2] = 32'hFFFFFFFE; vlo[2] = 32'hFFFFFFFD; vhi[2] = 32'd1;
    vop[3] = MD_DIV;  va[3] = 32'h80000000; vb[3] = 32'hFFFFFFFF; vlo[3] = 32'h80000000; vhi[3] = 32'd0;
    vop[4] = MD_DIVU; va[4] = 32'd5;        vb[4] = 32'd0;        vlo[4] = 32'hFFFFFFFF; vhi[4] = 32'd5;
    vop[5] = MD_DIV;  va[5] = 32'hFFFFFFFB; vb[5] = 32'd0;        vlo[5] = 32'hFFFFFFFF; vhi[5] = 32'hFFFFFFFB;
    vop[6] = MD_DIVU; va[6] = 32'hFFFFFFFF; vb[6] = 32'd16;       vlo[6] = 32'h0FFFFFFF; vhi[6] = 32'd15;
    for (int i = 0; i < 7; i++) begin
      issue(vop[i], va[i], vb[i]);
      step(W);
      total++;
      if ({bus.done, bus.busy} !== 2'b01) begin
        bad++; $display("FAIL div%0d_early: got done/busy=%b want 01", i, {bus.done, bus.busy});
      end
      step(1);
      total++;
      if ({bus.done, bus.busy} !== 2'b10) begin
        bad++; $display("FAIL div%0d_done: got done/busy=%b want 10", i, {bus.done, bus.busy});
      end
      total++;
      if ({bus.hi, bus.lo} !== {vhi[i], vlo[i]}) begin
        bad++; $display("FAIL div%0d_result: got hi/lo %h want %h", i, {bus.hi, bus.lo}, {vhi[i], vlo[i]});
      end
    end
  endtask

  task automatic test_mt();
    issue(MD_MTHI, 32'h1234, 32'h0);
    total++;
    if ({bus.busy, bus.hi} !== {1'b0, 32'h1234}) begin
      bad++; $display("FAIL mthi: got busy/hi %b/%h want 0/00001234", bus.busy, bus.hi);
    end
    bus.start = 1'b1;
    bus.op    = MD_MTLO;
    bus.a     = 32'h5678;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    total++;
    if ({bus.busy, bus.done, bus.hi, bus.lo} !== {2'b00, 32'h1234, 32'h5678}) begin
      bad++; $display("FAIL mtlo: got busy/done/hi/lo %b/%b/%h/%h want 0/0/00001234/00005678", bus.busy, bus.done, bus.hi, bus.lo);
    end
  endtask

  task automatic test_flush();
    logic saw_done;
    issue(MD_MTHI, 32'hAAAA, 32'h0);
    issue(MD_MTLO, 32'hBBBB, 32'h0);
    issue(MD_MULT, 32'd3, 32'd5);      // edge 0
    step(4);
    issue(MD_MTHI, 32'hDEAD, 32'h0);   // pulsed at edge 5, must be ignored
    total++;
    if ({bus.busy, bus.hi} !== {1'b1, 32'hAAAA}) begin
      bad++; $display("FAIL start_while_busy: got busy/hi %b/%h want 1/0000aaaa", bus.busy, bus.hi);
    end
    step(5);                           // just past edge 10
    bus.flush = 1'b1;
    step(1);                           // edge 11
    bus.flush = 1'b0;
    total++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      bad++; $display("FAIL flush_idle: got busy/done=%b want 00", {bus.busy, bus.done});
    end
    saw_done = 1'b0;
    for (int i = 0; i < W + 4; i++) begin
      step(1);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) saw_done = 1'b1;
    end
    total++;
    if (saw_done !== 1'b0) begin
      bad++; $display("FAIL flush_no_done: got activity=%b want 0", saw_done);
    end
    total++;
    if ({bus.hi, bus.lo} !== {32'hAAAA, 32'hBBBB}) begin
      bad++; $display("FAIL flush_hilo: got %h want 0000aaaa0000bbbb", {bus.hi, bus.lo});
    end
    // flush beats start in IDLE, for both MT and arithmetic requests
    @(negedge clk);
    bus.flush = 1'b1;
    bus.start = 1'b1;
    bus.op    = MD_MTHI;
    bus.a     = 32'hCCCC;
    @(posedge clk);
    #1;
    bus.op    = MD_DIVU;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    total++;
    if ({bus.busy, bus.hi} !== {1'b0, 32'hAAAA}) begin
      bad++; $display("FAIL flush_start_idle: got busy/hi %b/%h want 0/0000aaaa", bus.busy, bus.hi);
    end
  endtask

  task automatic test_back_to_back();
    issue(MD_DIVU, 32'd100, 32'd7);
    step(W + 1);
    total++;
    if ({bus.done, bus.hi, bus.lo} !== {1'b1, 32'd2, 32'd14}) begin
      bad++; $display("FAIL b2b_first: got done/hi/lo %b/%h/%h want 1/00000002/0000000e", bus.done, bus.hi, bus.lo);
    end
    issue(MD_MULTU, 32'd6, 32'd7);     // accepted in the done cycle
    total++;
    if ({bus.busy, bus.done} !== 2'b10) begin
      bad++; $display("FAIL b2b_accept: got busy/done=%b want 10", {bus.busy, bus.done});
    end
    step(W);
    total++;
    if (bus.done !== 1'b0) begin
      bad++; $display("FAIL b2b_early: got done=%b want 0", bus.done);
    end
    step(1);
    total++;
    if ({bus.done, bus.hi, bus.lo} !== {1'b1, 32'd0, 32'd42}) begin
      bad++; $display("FAIL b2b_second: got done/hi/lo %b/%h/%h want 1/00000000/0000002a", bus.done, bus.hi, bus.lo);
    end
  endtask

  task automatic test_reset_mid();
    issue(MD_DIV, 32'd100, 32'd7);
    step(10);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.busy, bus.done, bus.hi, bus.lo} !== 66'h0) begin
      bad++; $display("FAIL reset_mid: got busy/done/hi/lo %b/%b/%h/%h want all 0", bus.busy, bus.done, bus.hi, bus.lo);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(2);
    total++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      bad++; $display("FAIL reset_release: got busy/done=%b want 00", {bus.busy, bus.done});
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.op    = MD_MULT;
    bus.a     = '0;
    bus.b     = '0;
    bus.flush = 1'b0;
    test_reset();
    test_mul();
    test_div();
    test_mt();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_muldiv.md
# mips_muldiv

Iterative multiply/divide unit for the MIPS execute stage; implements MULT, MULTU, DIV, DIVU into private HI/LO registers, plus MTHI/MTLO writes. Width is parametrised, so the same block serves 32-bit and reduced-width test cores. Sits beside the single-cycle ALU. The pipeline stalls on `busy` and reads HI/LO directly for MFHI/MFLO.

## Interface
- `WIDTH`, 32: operand, HI and LO width; must be at least 2.
- `CNT_W`, $clog2(WIDTH+1): iteration counter width; derived, do not override.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  request strobe; accepted only while `busy`=0.
- `op`  in  mdop_t  operation, sampled with `start`.
- `a`  in  WIDTH  rs operand (multiplicand/dividend); also MTHI/MTLO data.
- `b`  in  WIDTH  rt operand (multiplier/divisor).
- `flush`  in  1  abort any operation in flight (exception/branch squash).
- `busy`  out  1  high while in CALC or FIX.
- `done`  out  1  one-cycle pulse after HI/LO are written by an arithmetic op.
- `hi`  out  WIDTH  HI register (remainder / product high half).
- `lo`  out  WIDTH  LO register (quotient / product low half).

## Operation
- Reset values: state=IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, counter=0.
- States: IDLE, CALC, FIX. `busy` = (state != IDLE).
- IDLE, `start`=1, op MTHI/MTLO: write `a` to HI/LO on that edge; stay IDLE; no `done`.
- IDLE, `start`=1, arithmetic op: latch the operation and go to CALC with counter=0.
  - Signed ops latch |a| and |b| (two's-complement negate, WIDTH bits) and record the result signs.
  - Unsigned ops latch `a` and `b` unchanged.
- CALC: one radix-2 step per edge; the counter increments. Go to FIX on the edge where counter reaches WIDTH.
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring divide; WIDTH+1-bit partial remainder, one quotient bit per step.
- FIX: apply the signs, write HI/LO, return to IDLE, pulse `done`.
  - Signed product: negate all 2*WIDTH bits if the operand signs differ.
  - Quotient: negated if the operand signs differ. Remainder: takes the sign of the dividend.
- Divide by zero (b==0), signed or unsigned: LO = all ones, HI = `a`, with normal latency.
- Signed DIV of most-negative by -1: LO = most-negative, HI = 0. No trap.
- `start` while `busy`: ignored, no side effects.
- `flush` while busy: go to IDLE on the next edge; HI/LO unchanged; no `done`.
- `flush` and `start` together in IDLE: flush wins and the request is dropped, including MTHI/MTLO.
- Reset mid-operation: immediate return to reset values.

## Timing
- Arithmetic op with `start` sampled at edge 0:
  - CALC from edge 0 to edge WIDTH; FIX at edge WIDTH+1.
  - `busy`=1 from edge 0 to edge WIDTH+1.
  - HI/LO are updated at edge WIDTH+1; `done`=1 for the cycle after it, with `busy`=0 in that same cycle.
  - For WIDTH=32: the `done` cycle follows edge 33.
- A new `start` may be accepted in the `done` cycle, giving back-to-back throughput of WIDTH+2 cycles.
- MTHI/MTLO: value visible on `hi`/`lo` in the cycle after the accepting edge.
- `hi`/`lo` are registered outputs with no combinational path from inputs.

## Structure
- Add to the shared MIPS definitions package:
  - `typedef enum logic [2:0] {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO} mdop_t`.
  - Function codes: FUNC_MFHI=6'b010000, FUNC_MTHI=6'b010001, FUNC_MFLO=6'b010010, FUNC_MTLO=6'b010011, FUNC_MULT=6'b011000, FUNC_MULTU=6'b011001, FUNC_DIV=6'b011010, FUNC_DIVU=6'b011011.
- State enum is local to the module.
- Single module; no sub-module needed. The mul and div datapaths share the accumulator register.

## Test plan
- MULT a=0xFFFFFFFE, b=3 -> `done` after edge 33; HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU a=b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV a=-7 (0xFFFFFFF9), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU a=7, b=2 -> LO=3, HI=1.
- DIV a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0. DIVU a=5, b=0 -> LO=0xFFFFFFFF, HI=5.
- MULT started and `flush` asserted at edge 10 -> `busy`=0 after edge 11, no `done`, HI/LO keep prior values. A `start` pulsed at edge 5 is ignored.
- MTHI 0x1234 then MTLO 0x5678 in consecutive cycles -> hi=0x1234, lo=0x5678, `busy` never set. `rst_n` low mid-DIV -> all outputs 0 immediately.
